pcie_mwr_tlp_gen: RTL and testbench
===================================

Name: pcie_mwr_tlp_gen

Overview:
- AXI4 write slave that converts each write burst into one PCIe Memory-Write TLP.
- Drives TLP header fields, a 1024-bit payload bus and the target address to the downstream PCIe link layer.
- An APB slave holds the requester ID, completer ID and traffic class used in the header.
- Sits between the SoC AXI fabric and the PCIe transaction layer. Read channels are not part of this block.

Parameters:
- ADDR_W, 32, AXI/TLP address width
- DATA_W, 128, AXI W data width
- ID_W, 4, AXI ID width
- MAX_BEATS, 8, maximum beats per burst (MAX_BEATS*DATA_W = 1024)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high
- psel/penable/pwrite  in  1 each  APB control
- paddr  in  12  APB address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready/pslverr  out  1 each  APB ready / error
- awvalid  in  1; awready  out  1  AW handshake
- awid  in  ID_W; awaddr  in  ADDR_W; awlen  in  8; awsize  in  3; awburst  in  2  AW payload
- wvalid  in  1; wready  out  1  W handshake
- wdata  in  DATA_W; wstrb  in  16; wlast  in  1  W payload
- bvalid  out  1; bready  in  1; bid  out  ID_W; bresp  out  2  write response
- tlp_valid  out  1  one-cycle strobe when header and data outputs update
- header_fmt_o  out  3; header_type_o  out  5; header_tc_o  out  3; header_length_o  out  9
- header_requestID_o  out  16; header_completID_o  out  16
- data_out  out  1024  payload, beat k at bits [128k+127:128k]
- addr_out  out  32  TLP address

Behaviour:
- Reset (rst_n=1, async):
  - All outputs are 0, except the registers below.
  - FSM goes to IDLE. Beat counter and error flag clear.
  - Register resets: REQ_ID=16'h0100, CPL_ID=16'h0000, TC=0, TLP_COUNT=0.
  - Reset during a burst aborts it: no TLP and no B response are produced.
- APB:
  - pready is always 1. A write commits on psel&penable&pwrite.
  - prdata is combinational on psel.
  - Register map:
    - 0x00 REQ_ID[15:0] RW
    - 0x04 CPL_ID[15:0] RW
    - 0x08 TC[2:0] RW
    - 0x0C TLP_COUNT[31:0] RO, incremented per TLP and wraps at 2^32
  - Any other offset, or a write to 0x0C: pslverr=1 and no effect.
- FSM IDLE→COLLECT→EMIT→RESP→IDLE.
  - IDLE/COLLECT:
    - awready=1 until AW is captured.
    - wready=1 until wlast is captured.
    - AW and W may arrive in any order, including W beats before AW.
    - Each W beat writes wdata into data buffer slot [beat_cnt], then beat_cnt++.
    - A beat when beat_cnt==MAX_BEATS is discarded and sets err.
  - Transition to EMIT once both AW and wlast are captured.
  - EMIT (1 cycle):
    - tlp_valid=1.
    - header_fmt_o=3'b010 (3DW with data). header_type_o=5'b00000 (MWr).
    - header_tc_o=TC, header_requestID_o=REQ_ID, header_completID_o=CPL_ID.
    - header_length_o = beats*4 (DW count; 2 beats → 9'd8).
    - addr_out=awaddr. data_out=buffer; slots not written this burst are 0.
    - TLP_COUNT++.
    - Outputs hold until the next EMIT.
  - RESP:
    - bvalid=1, bid=captured awid.
    - bresp=2'b00, or 2'b10 (SLVERR) if err, awburst≠INCR(2'b01), awsize≠3'd4, or beats≠awlen+1.
    - On an error the TLP is still emitted.
    - Leave RESP on bvalid&bready. bvalid stays asserted until bready.
- A new AW or W is not accepted until the FSM returns to IDLE.

Optional Feature:
- Macro TLP_WSTRB_MASK_EN.
- Defined: bytes whose wstrb bit is 0 are stored as 8'h00 in the data buffer.
- Undefined: wstrb is ignored and wdata is stored unmodified.

Decomposition:
- Package pcie_tlp_pkg contains:
  - FMT/TYPE constants and AXI resp/burst/size codes
  - APB register offsets and reset values
  - FSM state enum
- Sub-module pcie_apb_regs: the APB register file, exporting REQ_ID/CPL_ID/TC and taking a tlp_inc pulse.

Test Plan:
- Write at 0x0: AW len=1, size=4, INCR, id=0, data {8{32'h01234567}} → tlp_valid once; fmt=3'b010, type=0, length=8, addr_out=0; data_out[255:0]={8{32'h01234567}}, upper 768 bits 0; bresp=00, bid=0.
- Second write at 0x20 → addr_out=32'h20, TLP_COUNT reads 2.
- APB write REQ_ID=16'hABCD, TC=3, then a write burst → header_requestID_o=16'hABCD, header_tc_o=3.
- W beats driven 3 cycles before AW → identical TLP; bresp=00.
- awburst=FIXED, or 9 beats with awlen=8 → TLP still emitted; bresp=2'b10.
- rst_n asserted mid-COLLECT → no tlp_valid, no bvalid; next burst behaves normally.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared definitions for the AXI4-write to PCIe Memory-Write TLP generator:
// TLP header codes, AXI response/burst/size codes, APB register map,
// register reset values and the generator FSM state type.
package pcie_tlp_pkg;

  // TLP header codes
  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TYPE_MWR     = 5'b00000;

  // AXI codes
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_16B     = 3'd4;

  // APB register offsets
  localparam logic [11:0] REG_REQ_ID    = 12'h000;
  localparam logic [11:0] REG_CPL_ID    = 12'h004;
  localparam logic [11:0] REG_TC        = 12'h008;
  localparam logic [11:0] REG_TLP_COUNT = 12'h00C;

  // APB register reset values
  localparam logic [15:0] REQ_ID_RST    = 16'h0100;
  localparam logic [15:0] CPL_ID_RST    = 16'h0000;
  localparam logic [2:0]  TC_RST        = 3'd0;
  localparam logic [31:0] TLP_COUNT_RST = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_RESP    = 2'd3
  } tlp_state_e;

  // Zero every byte of a 128-bit beat whose strobe bit is clear
  function automatic logic [127:0] strb_mask(input logic [127:0] data,
                                             input logic [15:0]  strb);
    logic [127:0] res;
    res = data;
    for (int b = 0; b < 16; b++) begin
      if (!strb[b]) res[b*8 +: 8] = 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/pcie_apb_regs.sv
// APB register file for the MWr TLP generator: requester ID, completer ID,
// traffic class and a read-only count of emitted TLPs. pready is tied high;
// prdata/pslverr are combinational so a transfer completes in its access phase.
// Note: the reset input keeps the legacy name rst_n but is active-high.
module pcie_apb_regs
  import pcie_tlp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        tlp_inc,
  output logic [15:0] req_id,
  output logic [15:0] cpl_id,
  output logic [2:0]  tc
);

  logic [15:0] req_id_r;
  logic [15:0] cpl_id_r;
  logic [2:0]  tc_r;
  logic [31:0] tlp_count_r;
  logic [31:0] rd_data_s;
  logic        addr_ok_s;
  logic        wr_en_s;
  logic        unused_pwdata_s;

  // Address decode: read mux and legality of the current access
  always_comb begin
    rd_data_s = 32'h0000_0000;
    addr_ok_s = 1'b0;
    case (paddr)
      REG_REQ_ID: begin
        rd_data_s = {16'h0000, req_id_r};
        addr_ok_s = 1'b1;
      end
      REG_CPL_ID: begin
        rd_data_s = {16'h0000, cpl_id_r};
        addr_ok_s = 1'b1;
      end
      REG_TC: begin
        rd_data_s = {29'd0, tc_r};
        addr_ok_s = 1'b1;
      end
      REG_TLP_COUNT: begin
        rd_data_s = tlp_count_r;
        addr_ok_s = ~pwrite;
      end
      default: begin
        rd_data_s = 32'h0000_0000;
        addr_ok_s = 1'b0;
      end
    endcase
  end

  assign prdata          = psel ? rd_data_s : 32'h0000_0000;
  assign pready          = 1'b1;
  assign pslverr         = psel & penable & ~addr_ok_s;
  assign wr_en_s         = psel & penable & pwrite & addr_ok_s;
  assign unused_pwdata_s = ^pwdata[31:16];

  // Register writes and TLP counter (wraps naturally at 2^32)
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      req_id_r    <= REQ_ID_RST;
      cpl_id_r    <= CPL_ID_RST;
      tc_r        <= TC_RST;
      tlp_count_r <= TLP_COUNT_RST;
    end else begin
      if (wr_en_s) begin
        case (paddr)
          REG_REQ_ID: req_id_r <= pwdata[15:0];
          REG_CPL_ID: cpl_id_r <= pwdata[15:0];
          REG_TC:     tc_r     <= pwdata[2:0];
          default:    ;
        endcase
      end
      if (tlp_inc) tlp_count_r <= tlp_count_r + 32'd1;
    end
  end

  assign req_id = req_id_r;
  assign cpl_id = cpl_id_r;
  assign tc     = tc_r;

endmodule

// File: rtl/pcie_mwr_tlp_gen.sv
// AXI4 write slave that turns each write burst into one PCIe Memory-Write TLP.
// AW and W are collected in any order; once both the address and the last
// beat are in, the TLP header/payload/address outputs update with a one-cycle
// tlp_valid strobe and the B response is raised together with it.
// Optional build macro TLP_WSTRB_MASK_EN: when defined, bytes with a clear
// wstrb bit are stored as zero; otherwise wstrb is ignored.
// Note: the reset input keeps the legacy name rst_n but is active-high.
module pcie_mwr_tlp_gen
  import pcie_tlp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [11:0]                 paddr,
  input  logic [31:0]                 pwdata,
  output logic [31:0]                 prdata,
  output logic                        pready,
  output logic                        pslverr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [ID_W-1:0]             awid,
  input  logic [ADDR_W-1:0]           awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [15:0]                 wstrb,
  input  logic                        wlast,
  output logic                        bvalid,
  input  logic                        bready,
  output logic [ID_W-1:0]             bid,
  output logic [1:0]                  bresp,
  output logic                        tlp_valid,
  output logic [2:0]                  header_fmt_o,
  output logic [4:0]                  header_type_o,
  output logic [2:0]                  header_tc_o,
  output logic [8:0]                  header_length_o,
  output logic [15:0]                 header_requestID_o,
  output logic [15:0]                 header_completID_o,
  output logic [MAX_BEATS*DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0]           addr_out
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int IDX_W = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] BEATS_FULL = CNT_W'(MAX_BEATS);

  tlp_state_e state_r, state_s;
  logic aw_got_r, aw_got_s;
  logic w_done_r, w_done_s;
  logic aw_hs_s, w_hs_s, b_hs_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              err_r;
  logic [ID_W-1:0]   awid_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [7:0]        awlen_r;
  logic [2:0]        awsize_r;
  logic [1:0]        awburst_r;
  logic [DATA_W-1:0] buf_r [MAX_BEATS];
  logic [DATA_W-1:0] wdata_s;
  logic [MAX_BEATS*DATA_W-1:0] buf_flat_s;
  logic [8:0]  len_s;
  logic [1:0]  resp_s;
  logic [15:0] req_id_s, cpl_id_s;
  logic [2:0]  tc_s;
  logic        tlp_inc_s;

  assign aw_hs_s   = awvalid & awready;
  assign w_hs_s    = wvalid & wready;
  assign b_hs_s    = bvalid & bready;
  assign tlp_inc_s = (state_r == ST_EMIT);

`ifdef TLP_WSTRB_MASK_EN
  assign wdata_s = strb_mask(wdata, wstrb);
`else
  logic unused_wstrb_s;
  assign wdata_s        = wdata;
  assign unused_wstrb_s = ^wstrb;
`endif

  pcie_apb_regs u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tlp_inc (tlp_inc_s),
    .req_id  (req_id_s),
    .cpl_id  (cpl_id_s),
    .tc      (tc_s)
  );

  // FSM state and capture-flag register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r  <= ST_IDLE;
      aw_got_r <= 1'b0;
      w_done_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      aw_got_r <= aw_got_s;
      w_done_r <= w_done_s;
    end
  end

  // Next state: collect AW and the last W beat in any order, then emit and respond
  always_comb begin
    state_s  = state_r;
    aw_got_s = aw_got_r;
    w_done_s = w_done_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (aw_hs_s) aw_got_s = 1'b1;
        else         aw_got_s = aw_got_r;
        if (w_hs_s && wlast) w_done_s = 1'b1;
        else                 w_done_s = w_done_r;
        if (aw_got_s && w_done_s)            state_s = ST_EMIT;
        else if (aw_got_s || w_done_s || w_hs_s) state_s = ST_COLLECT;
        else                                 state_s = state_r;
      end
      ST_EMIT: begin
        state_s  = ST_RESP;
        aw_got_s = 1'b0;
        w_done_s = 1'b0;
      end
      ST_RESP: begin
        if (b_hs_s) state_s = ST_IDLE;
        else        state_s = ST_RESP;
      end
      default: begin
        state_s  = ST_IDLE;
        aw_got_s = 1'b0;
        w_done_s = 1'b0;
      end
    endcase
  end

  // AW capture, beat buffer fill and overflow flag; buffer clears at burst end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      awid_r     <= '0;
      awaddr_r   <= '0;
      awlen_r    <= 8'd0;
      awsize_r   <= 3'd0;
      awburst_r  <= 2'd0;
      beat_cnt_r <= '0;
      err_r      <= 1'b0;
      for (int k = 0; k < MAX_BEATS; k++) buf_r[k] <= '0;
    end else begin
      if (aw_hs_s) begin
        awid_r    <= awid;
        awaddr_r  <= awaddr;
        awlen_r   <= awlen;
        awsize_r  <= awsize;
        awburst_r <= awburst;
      end
      if (state_r == ST_RESP && b_hs_s) begin
        beat_cnt_r <= '0;
        err_r      <= 1'b0;
        for (int k = 0; k < MAX_BEATS; k++) buf_r[k] <= '0;
      end else if (w_hs_s) begin
        if (beat_cnt_r == BEATS_FULL) begin
          err_r <= 1'b1;
        end else begin
          buf_r[beat_cnt_r[IDX_W-1:0]] <= wdata_s;
          beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Flatten the beat buffer, derive DW length and the burst response code
  always_comb begin
    buf_flat_s = '0;
    for (int k = 0; k < MAX_BEATS; k++) buf_flat_s[k*DATA_W +: DATA_W] = buf_r[k];
    len_s = 9'(beat_cnt_r) * 9'd4;
    if (err_r || (awburst_r != BURST_INCR) || (awsize_r != SIZE_16B) ||
        (9'(beat_cnt_r) != ({1'b0, awlen_r} + 9'd1))) begin
      resp_s = RESP_SLVERR;
    end else begin
      resp_s = RESP_OKAY;
    end
  end

  // Registered handshake, TLP and response outputs; TLP fields hold until next emit
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      awready            <= 1'b0;
      wready             <= 1'b0;
      bvalid             <= 1'b0;
      bid                <= '0;
      bresp              <= 2'b00;
      tlp_valid          <= 1'b0;
      header_fmt_o       <= 3'd0;
      header_type_o      <= 5'd0;
      header_tc_o        <= 3'd0;
      header_length_o    <= 9'd0;
      header_requestID_o <= 16'h0000;
      header_completID_o <= 16'h0000;
      data_out           <= '0;
      addr_out           <= '0;
    end else begin
      awready   <= ((state_s == ST_IDLE) || (state_s == ST_COLLECT)) && !aw_got_s;
      wready    <= ((state_s == ST_IDLE) || (state_s == ST_COLLECT)) && !w_done_s;
      bvalid    <= (state_s == ST_RESP);
      tlp_valid <= (state_r == ST_EMIT);
      if (state_r == ST_EMIT) begin
        header_fmt_o       <= FMT_3DW_DATA;
        header_type_o      <= TYPE_MWR;
        header_tc_o        <= tc_s;
        header_length_o    <= len_s;
        header_requestID_o <= req_id_s;
        header_completID_o <= cpl_id_s;
        data_out           <= buf_flat_s;
        addr_out           <= awaddr_r;
        bid                <= awid_r;
        bresp              <= resp_s;
      end
    end
  end

endmodule

// File: tb/tb_pcie_mwr_tlp_gen.sv
// Self-checking bench for pcie_mwr_tlp_gen: directed cases plus randomized
// bursts checked against a transaction-level model of the TLP contents.
`timescale 1ns/1ps
module tb_pcie_mwr_tlp_gen;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]   paddr = 12'h000;
  logic [31:0]   pwdata = 32'h0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic          awvalid = 1'b0, awready;
  logic [3:0]    awid = 4'h0;
  logic [31:0]   awaddr = 32'h0;
  logic [7:0]    awlen = 8'h0;
  logic [2:0]    awsize = 3'h0;
  logic [1:0]    awburst = 2'h0;
  logic          wvalid = 1'b0, wready;
  logic [127:0]  wdata = 128'h0;
  logic [15:0]   wstrb = 16'h0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          tlp_valid;
  logic [2:0]    h_fmt, h_tc;
  logic [4:0]    h_type;
  logic [8:0]    h_len;
  logic [15:0]   h_req, h_cpl;
  logic [1023:0] data_out;
  logic [31:0]   addr_out;

  always #5 clk = ~clk;

  pcie_mwr_tlp_gen dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .tlp_valid(tlp_valid),
    .header_fmt_o(h_fmt), .header_type_o(h_type), .header_tc_o(h_tc),
    .header_length_o(h_len), .header_requestID_o(h_req), .header_completID_o(h_cpl),
    .data_out(data_out), .addr_out(addr_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0]  m_req = 16'h0100;
  logic [15:0]  m_cpl = 16'h0000;
  logic [2:0]   m_tc  = 3'd0;
  logic [31:0]  m_cnt = 32'd0;
  logic [127:0] bt_data [16];
  logic [15:0]  bt_strb [16];

  // TLP monitor: counts strobes and snapshots the outputs on each one
  int            tlp_seen = 0;
  logic [1023:0] cap_data;
  logic [31:0]   cap_addr;
  logic [8:0]    cap_len;
  logic [2:0]    cap_fmt, cap_tc;
  logic [4:0]    cap_type;
  logic [15:0]   cap_req, cap_cpl;
  always @(negedge clk) begin
    if (tlp_valid === 1'b1) begin
      tlp_seen++;
      cap_data = data_out; cap_addr = addr_out; cap_len = h_len;
      cap_fmt = h_fmt; cap_tc = h_tc; cap_type = h_type;
      cap_req = h_req; cap_cpl = h_cpl;
    end
  end

  function automatic logic [127:0] exp_beat(input int k);
    logic [127:0] d;
    d = bt_data[k];
`ifdef TLP_WSTRB_MASK_EN
    for (int b = 0; b < 16; b++) if (!bt_strb[k][b]) d[b*8 +: 8] = 8'h00;
`endif
    return d;
  endfunction

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); d = prdata; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic fill_random(input int nb);
    for (int i = 0; i < nb; i++) begin
      bt_data[i] = {$urandom, $urandom, $urandom, $urandom};
      bt_strb[i] = 16'($urandom);
    end
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [3:0] id, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awvalid = 1'b1; awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id;
    n = 0;
    @(negedge clk);
    while (awready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check_val("aw_handshake", 128'(awready), 128'd1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic drive_w(input int nb, input int dly, input bit last_en);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = bt_data[i]; wstrb = bt_strb[i];
      wlast = last_en && (i == nb - 1);
      n = 0;
      @(negedge clk);
      while (wready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check_val("w_handshake", 128'(wready), 128'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // One complete burst, then compare TLP and B response with the model
  task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] id, input int nb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int seen0, n, nv;
    logic [1:0] e_resp;
    seen0 = tlp_seen;
    fork
      drive_aw(a, len, sz, bu, id, aw_dly);
      drive_w(nb, w_dly, 1'b1);
    join
    n = 0;
    @(negedge clk);
    while (bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check_val("bvalid_seen", 128'(bvalid), 128'd1);
    repeat (b_dly) @(negedge clk);
    check_val("bvalid_hold", 128'(bvalid), 128'd1);
    e_resp = ((nb > 8) || (bu != 2'b01) || (sz != 3'd4) || (nb != int'(len) + 1)) ? 2'b10 : 2'b00;
    check_val("bid", 128'(bid), 128'(id));
    check_val("bresp", 128'(bresp), 128'(e_resp));
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check_val("bvalid_drop", 128'(bvalid), 128'd0);
    check_val("tlp_count_burst", 128'(tlp_seen - seen0), 128'd1);
    m_cnt = m_cnt + 32'd1;
    nv = (nb > 8) ? 8 : nb;
    check_val("fmt", 128'(cap_fmt), 128'(3'b010));
    check_val("type", 128'(cap_type), 128'(5'b00000));
    check_val("tc", 128'(cap_tc), 128'(m_tc));
    check_val("req_id", 128'(cap_req), 128'(m_req));
    check_val("cpl_id", 128'(cap_cpl), 128'(m_cpl));
    check_val("length", 128'(cap_len), 128'(nv * 4));
    check_val("addr", 128'(cap_addr), 128'(a));
    for (int k = 0; k < 8; k++)
      check_val($sformatf("data_slot%0d", k), cap_data[k*128 +: 128],
                (k < nv) ? exp_beat(k) : 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          nb, mode, seen0, bcnt;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;

    // Reset
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_awready", 128'(awready), 128'd0);
    check_val("rst_bvalid", 128'(bvalid), 128'd0);
    check_val("rst_tlp_valid", 128'(tlp_valid), 128'd0);
    check_val("rst_addr_out", 128'(addr_out), 128'd0);
    check_val("rst_data_lo", data_out[127:0], 128'd0);
    check_val("rst_req_out", 128'(h_req), 128'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("pready", 128'(pready), 128'd1);
    apb_rd(12'h000, rd, err); check_val("rd_req_id_rst", 128'(rd), 128'h0100);
    apb_rd(12'h004, rd, err); check_val("rd_cpl_id_rst", 128'(rd), 128'h0000);
    apb_rd(12'h008, rd, err); check_val("rd_tc_rst", 128'(rd), 128'h0);
    apb_rd(12'h00C, rd, err); check_val("rd_count_rst", 128'(rd), 128'h0);

    // First burst at 0x0: two beats of {8{32'h01234567}}
    for (int i = 0; i < 2; i++) begin
      bt_data[i] = {4{32'h01234567}};
      bt_strb[i] = 16'hFFFF;
    end
    run_burst(32'h0, 8'd1, 3'd4, 2'b01, 4'h0, 2, 0, 0, 0);

    // Second burst at 0x20, then TLP_COUNT reads 2
    fill_random(2);
    run_burst(32'h20, 8'd1, 3'd4, 2'b01, 4'h5, 2, 0, 0, 1);
    apb_rd(12'h00C, rd, err); check_val("rd_count_2", 128'(rd), 128'(m_cnt));

    // Header fields from programmed registers
    apb_wr(12'h000, 32'h0000ABCD, err); m_req = 16'hABCD;
    check_val("wr_req_slverr", 128'(err), 128'd0);
    apb_wr(12'h008, 32'h00000003, err); m_tc = 3'd3;
    apb_wr(12'h004, 32'h00001234, err); m_cpl = 16'h1234;
    fill_random(4);
    run_burst(32'h1000, 8'd3, 3'd4, 2'b01, 4'hA, 4, 1, 0, 0);

    // W beats ahead of AW
    fill_random(3);
    run_burst(32'h2040, 8'd2, 3'd4, 2'b01, 4'h3, 3, 3, 0, 2);

    // Error bursts: FIXED burst, and nine beats with awlen=8
    fill_random(2);
    run_burst(32'h3000, 8'd1, 3'd4, 2'b00, 4'h7, 2, 0, 0, 0);
    fill_random(9);
    run_burst(32'h4000, 8'd8, 3'd4, 2'b01, 4'h9, 9, 0, 0, 0);

    // Illegal APB accesses
    apb_wr(12'h010, 32'hFFFF_FFFF, err); check_val("slverr_bad_off", 128'(err), 128'd1);
    apb_wr(12'h00C, 32'h0000_0055, err); check_val("slverr_wr_count", 128'(err), 128'd1);
    apb_rd(12'h00C, rd, err);
    check_val("rd_count_after_bad", 128'(rd), 128'(m_cnt));
    check_val("rd_count_slverr", 128'(err), 128'd0);

    // Reset in the middle of collecting a burst
    fill_random(4);
    seen0 = tlp_seen;
    fork
      drive_aw(32'h5000, 8'd3, 3'd4, 2'b01, 4'h2, 0);
      drive_w(2, 0, 1'b0);
    join
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    m_req = 16'h0100; m_cpl = 16'h0000; m_tc = 3'd0; m_cnt = 32'd0;
    bcnt = 0;
    repeat (12) begin @(negedge clk); if (bvalid === 1'b1) bcnt++; end
    check_val("abort_no_bvalid", 128'(bcnt), 128'd0);
    check_val("abort_no_tlp", 128'(tlp_seen - seen0), 128'd0);
    @(posedge clk); #1;
    apb_rd(12'h000, rd, err); check_val("rd_req_after_rst", 128'(rd), 128'h0100);
    fill_random(3);
    run_burst(32'h6000, 8'd2, 3'd4, 2'b01, 4'h1, 3, 0, 1, 0);

    // Randomized bursts and register updates
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_req = 16'($urandom); apb_wr(12'h000, {16'h0, m_req}, err);
        m_cpl = 16'($urandom); apb_wr(12'h004, {16'h0, m_cpl}, err);
        m_tc  = 3'($urandom);  apb_wr(12'h008, {29'd0, m_tc}, err);
      end
      nb = $urandom_range(1, 8);
      len = 8'(nb - 1); sz = 3'd4; bu = 2'b01;
      mode = $urandom_range(0, 6);
      case (mode)
        0: len = 8'($urandom_range(0, 9));
        1: bu = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        2: sz = 3'($urandom_range(0, 3));
        3: begin nb = 9; len = 8'd8; end
        default: ;
      endcase
      fill_random(nb);
      run_burst({$urandom} & 32'hFFFF_FFF0, len, sz, bu, 4'($urandom), nb,
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
    end
    apb_rd(12'h00C, rd, err); check_val("rd_count_final", 128'(rd), 128'(m_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
